// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the number-guessing game display path.
//   result_t    : 2-bit comparison code produced by the game logic
//   GLYPH_*     : active-high 7-segment patterns, bit6..bit0 = a,b,c,d,e,f,g
//   BLINK_DIV_* : legal range of the blink half-period parameter
// ----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        RES_CORRECT = 2'b00,
        RES_UP      = 2'b01,
        RES_DOWN    = 2'b10,
        RES_INVALID = 2'b11
    } result_t;

    // Active-high glyphs (a..g); the top inverts them for common-anode boards.
    localparam logic [6:0] GLYPH_C     = 7'b1001110;
    localparam logic [6:0] GLYPH_U     = 7'b0111110;
    localparam logic [6:0] GLYPH_D     = 7'b0111101;
    localparam logic [6:0] GLYPH_DASH  = 7'b0000001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    localparam int unsigned BLINK_DIV_MIN = 2;
    localparam int unsigned BLINK_DIV_MAX = 32'd1 << 26;

endpackage : display_pkg

// File: rtl/seg_glyph_decoder.sv
// ----------------------------------------------------------------------------
// seg_glyph_decoder
// Purely combinational map from a comparison code to an active-high glyph.
// Polarity and registering are handled by the caller.
//   result : comparison code (result_t)
//   glyph  : active-high segment pattern, bit6..bit0 = a..g
// ----------------------------------------------------------------------------
module seg_glyph_decoder
    import display_pkg::*;
(
    input  result_t    result,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_DASH;
        case (result)
            RES_CORRECT: glyph = GLYPH_C;
            RES_UP:      glyph = GLYPH_U;
            RES_DOWN:    glyph = GLYPH_D;
            RES_INVALID: glyph = GLYPH_DASH;
            default:     glyph = GLYPH_DASH;
        endcase
    end

endmodule : seg_glyph_decoder

// File: rtl/display_control.sv
// ----------------------------------------------------------------------------
// display_control
// Registered 7-segment driver for the up/down guessing game. Shows "C", "U",
// "d" or "-" for the comparison code, one clock after it is sampled.
//
// Parameters
//   ACTIVE_LOW : 1 = segment lit when driven 0 (common anode), 0 = active-high
//   BLINK_DIV  : cycles per blink half-period (2 .. 2^26), blink build only
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset; blanks the digit at once
//   result      : comparison code 00 correct, 01 up, 10 down, 11 invalid
//   seg_display : registered segment drive, bit6..bit0 = a..g
//
// Build option
//   DISPLAY_BLINK_EN : when defined, "C" flashes with a BLINK_DIV-cycle
//                      half-period; all other glyphs stay steady.
// ----------------------------------------------------------------------------
module display_control
    import display_pkg::*;
#(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] result,
    output logic [6:0] seg_display
);

    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? ~GLYPH_BLANK : GLYPH_BLANK;

    if (BLINK_DIV < BLINK_DIV_MIN || BLINK_DIV > BLINK_DIV_MAX) begin : g_bad_blink_div
        $error("display_control: BLINK_DIV out of range");
    end

    result_t    res;
    logic [6:0] glyph;
    logic [6:0] shown;
    logic [6:0] seg_d;
    logic [6:0] seg_q;

    assign res = result_t'(result);

    seg_glyph_decoder u_dec (
        .result (res),
        .glyph  (glyph)
    );

`ifdef DISPLAY_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    result_t          prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_on_q, phase_on_d;

    // The counter tracks how many cycles the current phase has been shown.
    // Entering CORRECT restarts it with the phase on, so the first "on"
    // interval is a full BLINK_DIV cycles. Any other code parks it at 0.
    always_comb begin
        prev_d     = res;
        cnt_d      = '0;
        phase_on_d = 1'b1;
        if (res == RES_CORRECT && prev_q == RES_CORRECT) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                cnt_d      = cnt_q + CNT_W'(1);
                phase_on_d = phase_on_q;
            end
        end
        shown = glyph;
        if (res == RES_CORRECT && !phase_on_d)
            shown = GLYPH_BLANK;
    end

    // prev_q resets to a non-CORRECT code so the first CORRECT after reset
    // counts as an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= RES_INVALID;
            cnt_q      <= '0;
            phase_on_q <= 1'b1;
        end else begin
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            phase_on_q <= phase_on_d;
        end
    end
`else
    always_comb begin
        shown = glyph;
    end
`endif

    always_comb begin
        seg_d = ACTIVE_LOW ? ~shown : shown;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seg_q <= SEG_OFF;
        else     seg_q <= seg_d;
    end

    assign seg_display = seg_q;

endmodule : display_control

// File: tb/tb_display_control.sv
// ----------------------------------------------------------------------------
// tb_display_control
// Directed bench for display_control. Two instances share the stimulus:
// u_dut_al (ACTIVE_LOW=1) and u_dut_ah (ACTIVE_LOW=0), both BLINK_DIV=4.
// Blink sequences are only exercised when DISPLAY_BLINK_EN is defined.
// ----------------------------------------------------------------------------
module tb_display_control;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst    = 1'b0;
    logic [1:0] result = 2'b00;
    logic [6:0] seg_al;
    logic [6:0] seg_ah;

    int n_chk  = 0;
    int n_fail = 0;

    // Active-low expected glyphs (hand-derived)
    localparam logic [6:0] AL_C = 7'b0110001;
    localparam logic [6:0] AL_U = 7'b1000001;
    localparam logic [6:0] AL_D = 7'b1000010;
    localparam logic [6:0] AL_M = 7'b1111110;
    localparam logic [6:0] AL_O = 7'b1111111;
    // Active-high expected glyphs
    localparam logic [6:0] AH_C = 7'b1001110;
    localparam logic [6:0] AH_U = 7'b0111110;
    localparam logic [6:0] AH_D = 7'b0111101;
    localparam logic [6:0] AH_M = 7'b0000001;
    localparam logic [6:0] AH_O = 7'b0000000;

    display_control #(.ACTIVE_LOW(1'b1), .BLINK_DIV(4)) u_dut_al (
        .clk         (clk),
        .rst         (rst),
        .result      (result),
        .seg_display (seg_al)
    );

    display_control #(.ACTIVE_LOW(1'b0), .BLINK_DIV(4)) u_dut_ah (
        .clk         (clk),
        .rst         (rst),
        .result      (result),
        .seg_display (seg_ah)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_al", seg_al, AL_O);
        chk("rst_async_ah", seg_ah, AH_O);
        rst = 1'b0;
        #1;
        chk("rst_hold_al", seg_al, AL_O);
    endtask

    initial begin
        // Reset with the clock stopped: blanking must not need an edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_noclk_al", seg_al, AL_O);
        chk("rst_noclk_ah", seg_ah, AH_O);
        rst = 1'b0;
        #3;
        chk("rst_release_al", seg_al, AL_O);
        chk("rst_release_ah", seg_ah, AH_O);
        clk_en = 1'b1;

        // Glyph table, one edge after each code change.
        result = 2'b00; step(); chk("glyph_c_al", seg_al, AL_C); chk("glyph_c_ah", seg_ah, AH_C);
        result = 2'b01; step(); chk("glyph_u_al", seg_al, AL_U); chk("glyph_u_ah", seg_ah, AH_U);
        result = 2'b10; step(); chk("glyph_d_al", seg_al, AL_D); chk("glyph_d_ah", seg_ah, AH_D);
        result = 2'b11; step(); chk("glyph_m_al", seg_al, AL_M); chk("glyph_m_ah", seg_ah, AH_M);

        // Latency: changing the input between edges must not reach the pins.
        result = 2'b01; step(); chk("lat_u", seg_al, AL_U);
        result = 2'b10; #1;     chk("lat_hold_u", seg_al, AL_U);
        step();                 chk("lat_d", seg_al, AL_D);

        // Reset in mid-operation, then decoding resumes one edge later.
        pulse_rst();
        result = 2'b11; step(); chk("post_rst_m", seg_al, AL_M);

`ifdef DISPLAY_BLINK_EN
        // Steady CORRECT: 4 on, 4 off, repeating, starting on.
        pulse_rst();
        result = 2'b00;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("blink_%0d", i), seg_al, ((i / 4) % 2 == 0) ? AL_C : AL_O);
        end

        // CORRECT for 6 cycles, then UP (steady), then back: fresh "on" phase.
        pulse_rst();
        result = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("pre_u_%0d", i), seg_al, (i < 4) ? AL_C : AL_O);
        end
        result = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("u_steady_%0d", i), seg_al, AL_U);
        end
        result = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("reentry_%0d", i), seg_al, (i < 4) ? AL_C : AL_O);
        end

        // Reset during an "off" phase: blank at once, then a full "on" phase.
        pulse_rst();
        result = 2'b00;
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_off", seg_al, AL_O);
        pulse_rst();
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_blink_%0d", i), seg_al, (i < 4) ? AL_C : AL_O);
        end
`else
        // Without blinking, CORRECT holds steady.
        result = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("steady_c_%0d", i), seg_al, AL_C);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_display_control
